// File: rtl/hyperram_responder.sv
// HyperRAM device-side responder: decodes the 48-bit CA, applies initial latency and serves
// memory or ID/CR register reads and writes, one 16-bit word per qualified clk cycle.
module hyperram_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 6,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] ID1_VAL = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic        ck_en,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic        rwds_in,
  output logic        rwds_out,
  output logic        rwds_oe
);

  localparam int unsigned CntW = $clog2(2 * LATENCY + 1);
  localparam logic [CntW-1:0] LatShort = CntW'(LATENCY);
  localparam logic [CntW-1:0] LatLong  = CntW'(2 * LATENCY);

  typedef enum logic [3:0] {
    StIdle, StCa0, StCa1, StCa2, StLat, StRdata, StWdata, StRegw, StHold
  } state_e;

  state_e            state_q, state_d;
  logic [14:0]       ca_hi_q, ca_hi_d;  // {CA[47:46], CA[44:32]}
  logic [15:0]       ca_mid_q, ca_mid_d;
  logic              is_read_q, is_read_d, is_reg_q, is_reg_d, lat2_q, lat2_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ca_addr;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       cr0_q, cr0_d, cr1_q, cr1_d;
  logic [15:0]       dq_out_q, dq_out_d, rd_word;
  logic              dq_oe_q, dq_oe_d, rwds_out_q, rwds_out_d, rwds_oe_q, rwds_oe_d;
  logic              mem_we, qual;
  logic [15:0]       mem [0:(1 << ADDR_W) - 1];

  assign qual    = ~csn & ck_en;
  assign ca_addr = ADDR_W'({ca_hi_q[12:0], ca_mid_q, dq_in[2:0]});

  always_comb begin
    rd_word = mem[addr_q];
    if (is_reg_q) begin
      unique case (sel_q)
        2'b00: rd_word = ID0_VAL;
        2'b01: rd_word = ID1_VAL;
        2'b10: rd_word = cr0_q;
        2'b11: rd_word = cr1_q;
      endcase
    end
  end

  // Output registers are loaded from the next state, so they are visible while in that state.
  always_comb begin
    state_d    = state_q;
    ca_hi_d    = ca_hi_q;
    ca_mid_d   = ca_mid_q;
    is_read_d  = is_read_q;
    is_reg_d   = is_reg_q;
    lat2_d     = lat2_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cr0_d      = cr0_q;
    cr1_d      = cr1_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = 1'b0;
    rwds_out_d = 1'b0;
    rwds_oe_d  = 1'b0;
    mem_we     = 1'b0;
    if (csn) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d    = StCa0;
          lat2_d     = cr0_q[3];
          rwds_oe_d  = 1'b1;
          rwds_out_d = cr0_q[3];
        end
        StCa0, StCa1: begin
          rwds_oe_d  = 1'b1;
          rwds_out_d = lat2_q;
          if (qual) begin
            if (state_q == StCa0) begin
              ca_hi_d = {dq_in[15:14], dq_in[12:0]};
              state_d = StCa1;
            end else begin
              ca_mid_d = dq_in;
              state_d  = StCa2;
            end
          end
        end
        StCa2: begin
          rwds_oe_d  = 1'b1;
          rwds_out_d = lat2_q;
          if (qual) begin
            is_read_d = ca_hi_q[14];
            is_reg_d  = ca_hi_q[13];
            sel_d     = {ca_mid_q[8], dq_in[0]};
            addr_d    = ca_addr;
            cnt_d     = lat2_q ? LatLong : LatShort;
            rwds_out_d = 1'b0;
            if (!ca_hi_q[14] && ca_hi_q[13]) begin
              state_d   = StRegw;
              rwds_oe_d = 1'b0;
            end else begin
              state_d   = StLat;
              rwds_oe_d = ca_hi_q[14];
            end
          end
        end
        StLat: begin
          rwds_oe_d = is_read_q;
          if (qual) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q <= CntW'(1)) begin
              state_d = is_read_q ? StRdata : StWdata;
              dq_oe_d = is_read_q;
            end
          end
        end
        StRdata: begin
          dq_oe_d   = 1'b1;
          rwds_oe_d = 1'b1;
          if (qual) begin
            dq_out_d   = rd_word;
            rwds_out_d = 1'b1;
            if (!is_reg_q) addr_d = addr_q + ADDR_W'(1);
          end
        end
        StWdata: begin
          if (qual) begin
            mem_we = ~rwds_in;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        StRegw: begin
          if (qual) begin
            if (sel_q == 2'b10) cr0_d = dq_in;
            if (sel_q == 2'b11) cr1_d = dq_in;
            state_d = StHold;
          end
        end
        StHold: state_d = StHold;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ca_hi_q    <= '0;
      ca_mid_q   <= '0;
      is_read_q  <= 1'b0;
      is_reg_q   <= 1'b0;
      lat2_q     <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      cr0_q      <= 16'h8F1F;
      cr1_q      <= 16'hFFC1;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ca_hi_q    <= ca_hi_d;
      ca_mid_q   <= ca_mid_d;
      is_read_q  <= is_read_d;
      is_reg_q   <= is_reg_d;
      lat2_q     <= lat2_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      cr0_q      <= cr0_d;
      cr1_q      <= cr1_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rwds_out_q <= rwds_out_d;
      rwds_oe_q  <= rwds_oe_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= dq_in;
  end

  assign dq_out   = dq_out_q;
  assign dq_oe    = dq_oe_q;
  assign rwds_out = rwds_out_q;
  assign rwds_oe  = rwds_oe_q;

endmodule
